// File: rtl/adam_fabric_lsxp_arb_if.sv
// Bus bundles for the lsxp bridge: AXI-Lite request/response channels and the multi-target APB side.
interface adam_fabric_lsxp_arb_axil_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [2:0]            aw_prot;
    logic                  aw_valid;
    logic                  aw_ready;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0] w_strb;
    logic                  w_valid;
    logic                  w_ready;
    logic [1:0]            b_resp;
    logic                  b_valid;
    logic                  b_ready;
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic [2:0]            ar_prot;
    logic                  ar_valid;
    logic                  ar_ready;
    logic [DATA_WIDTH-1:0] r_data;
    logic [1:0]            r_resp;
    logic                  r_valid;
    logic                  r_ready;

    modport master (
        output aw_addr, aw_prot, aw_valid, w_data, w_strb, w_valid, b_ready,
               ar_addr, ar_prot, ar_valid, r_ready,
        input  aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
    );
    modport slave (
        input  aw_addr, aw_prot, aw_valid, w_data, w_strb, w_valid, b_ready,
               ar_addr, ar_prot, ar_valid, r_ready,
        output aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
    );
endinterface

interface adam_fabric_lsxp_arb_apb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NO_MSTS    = 8
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0]         paddr;
    logic [2:0]                    pprot;
    logic                          pwrite;
    logic [DATA_WIDTH-1:0]         pwdata;
    logic [STRB_WIDTH-1:0]         pstrb;
    logic [NO_MSTS-1:0]            psel;
    logic                          penable;
    logic [NO_MSTS-1:0]            pready;
    logic [NO_MSTS*DATA_WIDTH-1:0] prdata;
    logic [NO_MSTS-1:0]            pslverr;

    modport master (
        output paddr, pprot, pwrite, pwdata, pstrb, psel, penable,
        input  pready, prdata, pslverr
    );
    modport slave (
        input  paddr, pprot, pwrite, pwdata, pstrb, psel, penable,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/adam_fabric_lsxp_arb.sv
// AXI-Lite slave to multi-target APB bridge: windowed decode, DECERR, ACCESS timeout,
// alternating read/write priority and a pause request/acknowledge handshake.
module adam_fabric_lsxp_arb #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           NO_MSTS    = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int unsigned           WIN_LOG2   = 10,
    parameter int unsigned           TIMEOUT    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pause_req,
    output logic                       pause_ack,
    adam_fabric_lsxp_arb_axil_if.slave axil,
    adam_fabric_lsxp_arb_apb_if.master apb
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned IDX_W      = (NO_MSTS > 1) ? $clog2(NO_MSTS) : 1;
    localparam int unsigned TCNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    state_t state, state_nx;

    logic                  wr_prio;
    logic                  is_write;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [2:0]            prot_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] strb_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [IDX_W-1:0]      idx_q;
    logic [1:0]            resp_q;
    logic [TCNT_W-1:0]     tcnt;

    logic wr_elig, rd_elig, accept_ok, pick_wr, wr_hs, rd_hs, hs;
    logic [ADDR_WIDTH-1:0] hs_addr, offset, win_idx;
    logic hit, sel_ready, sel_err, timeout_hit;
    logic [DATA_WIDTH-1:0] sel_rdata;

    // Readies are gated by reset too, so nothing looks accepted while rst is low.
    assign wr_elig   = axil.aw_valid && axil.w_valid;
    assign rd_elig   = axil.ar_valid;
    assign accept_ok = rst && (state == IDLE) && !pause_req;
    assign pick_wr   = wr_elig && (!rd_elig || wr_prio);
    assign wr_hs     = accept_ok && pick_wr;
    assign rd_hs     = accept_ok && rd_elig && !pick_wr;
    assign hs        = wr_hs || rd_hs;

    assign axil.aw_ready = wr_hs;
    assign axil.w_ready  = wr_hs;
    assign axil.ar_ready = rd_hs;

    assign hs_addr = pick_wr ? axil.aw_addr : axil.ar_addr;
    assign offset  = hs_addr - BASE_ADDR;
    assign win_idx = offset >> WIN_LOG2;
    assign hit     = (hs_addr >= BASE_ADDR) && (win_idx < ADDR_WIDTH'(NO_MSTS));

    assign sel_ready   = apb.pready[idx_q];
    assign sel_err     = apb.pslverr[idx_q];
    assign sel_rdata   = apb.prdata[idx_q*DATA_WIDTH +: DATA_WIDTH];
    assign timeout_hit = (TIMEOUT != 0) && (tcnt == TCNT_W'(TIMEOUT - 1));

    assign apb.paddr   = addr_q;
    assign apb.pprot   = prot_q;
    assign apb.pwrite  = is_write;
    assign apb.pwdata  = wdata_q;
    assign apb.pstrb   = strb_q;
    assign axil.b_resp = resp_q;
    assign axil.r_resp = resp_q;
    assign axil.r_data = rdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        apb.psel     = '0;
        apb.penable  = 1'b0;
        axil.b_valid = 1'b0;
        axil.r_valid = 1'b0;
        case (state)
            IDLE: begin
                if (hs) state_nx = hit ? SETUP : RESP;
            end
            SETUP: begin
                apb.psel[idx_q] = 1'b1;
                state_nx        = ACCESS;
            end
            ACCESS: begin
                apb.psel[idx_q] = 1'b1;
                apb.penable     = 1'b1;
                if (sel_ready || timeout_hit) state_nx = RESP;
            end
            RESP: begin
                axil.b_valid = is_write;
                axil.r_valid = !is_write;
                if (is_write ? axil.b_ready : axil.r_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pause_ack <= 1'b0;
            wr_prio   <= 1'b1;
            is_write  <= 1'b0;
            addr_q    <= '0;
            prot_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            rdata_q   <= '0;
            idx_q     <= '0;
            resp_q    <= '0;
            tcnt      <= '0;
        end else begin
            pause_ack <= (state == IDLE) && pause_req;
            if (hs) begin
                is_write <= pick_wr;
                if (wr_elig && rd_elig) wr_prio <= !wr_prio;
                addr_q  <= hs_addr;
                prot_q  <= pick_wr ? axil.aw_prot : axil.ar_prot;
                wdata_q <= pick_wr ? axil.w_data : '0;
                strb_q  <= pick_wr ? axil.w_strb : '0;
                idx_q   <= win_idx[IDX_W-1:0];
                if (!hit) begin
                    resp_q  <= 2'b11;
                    rdata_q <= '0;
                end
            end
            if (state == SETUP)       tcnt <= '0;
            else if (state == ACCESS) tcnt <= tcnt + 1'b1;
            if (state == ACCESS) begin
                if (sel_ready) begin
                    resp_q  <= sel_err ? 2'b10 : 2'b00;
                    rdata_q <= is_write ? '0 : sel_rdata;
                end else if (timeout_hit) begin
                    resp_q  <= 2'b10;
                    rdata_q <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_adam_fabric_lsxp_arb.sv
// Scoreboard bench for adam_fabric_lsxp_arb: expected responses are queued at issue and popped on completion.
module tb_adam_fabric_lsxp_arb;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NM = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic pause_req = 1'b0;
    logic pause_ack;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    adam_fabric_lsxp_arb_axil_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axil ();
    adam_fabric_lsxp_arb_apb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NO_MSTS(NM)) apb ();

    adam_fabric_lsxp_arb #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NO_MSTS(NM),
        .BASE_ADDR(32'h0), .WIN_LOG2(10), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst), .pause_req(pause_req), .pause_ack(pause_ack),
        .axil(axil), .apb(apb)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [NM-1:0]    tgt_ready = '1;
    logic [NM-1:0]    tgt_err = '0;
    logic [NM*DW-1:0] tgt_rdata;
    assign apb.pready  = tgt_ready;
    assign apb.pslverr = tgt_err;
    assign apb.prdata  = tgt_rdata;

    // Bus monitor: accumulates APB activity; tests read it between a posedge and the next negedge.
    int            pen_total = 0;
    int            psel_cnt[NM];
    int            psel_multi = 0;
    int            bval_total = 0;
    logic [AW-1:0] mon_paddr = '0;
    logic          mon_pwrite = 1'b0;
    logic [DW-1:0] mon_pwdata = '0;
    logic [3:0]    mon_pstrb = '0;
    always @(negedge clk) begin
        if (apb.penable) begin
            pen_total++;
            mon_paddr = apb.paddr; mon_pwrite = apb.pwrite;
            mon_pwdata = apb.pwdata; mon_pstrb = apb.pstrb;
        end
        for (int i = 0; i < NM; i++) if (apb.psel[i]) psel_cnt[i]++;
        if (!$onehot0(apb.psel)) psel_multi++;
        if (axil.b_valid) bval_total++;
    end

    typedef struct {
        logic [1:0]    resp;
        logic [DW-1:0] data;
        int            lat;
        logic [NM-1:0] pmask;
    } exp_t;
    exp_t sb[$];

    task automatic settle();
        @(posedge clk); #1;
    endtask

    task automatic issue(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data, output int hs);
        hs = -1;
        @(negedge clk);
        if (wr) begin
            axil.aw_addr = addr; axil.aw_prot = 3'b010; axil.w_data = data; axil.w_strb = 4'hF;
            axil.aw_valid = 1'b1; axil.w_valid = 1'b1;
        end else begin
            axil.ar_addr = addr; axil.ar_prot = 3'b001; axil.ar_valid = 1'b1;
        end
        for (int k = 0; k < 50; k++) begin
            #1;
            if (wr ? (axil.aw_ready && axil.w_ready) : axil.ar_ready) begin
                hs = cyc;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        if (wr) begin axil.aw_valid = 1'b0; axil.w_valid = 1'b0; end
        else axil.ar_valid = 1'b0;
    endtask

    task automatic wait_resp(input bit wr, output logic [1:0] resp, output logic [DW-1:0] data, output int vc);
        vc = -1; resp = 'x; data = 'x;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (wr ? axil.b_valid : axil.r_valid) begin
                vc = cyc; resp = wr ? axil.b_resp : axil.r_resp; data = axil.r_data;
                break;
            end
        end
    endtask

    // One complete transfer; returns only observations.
    task automatic xfer(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        output logic [1:0] resp, output logic [DW-1:0] rdata, output int lat,
                        output logic [NM-1:0] pmask, output int npen);
        int snap[NM];
        int pen0, hs, vc;
        settle();
        pen0 = pen_total;
        for (int i = 0; i < NM; i++) snap[i] = psel_cnt[i];
        issue(wr, addr, wdata, hs);
        wait_resp(wr, resp, rdata, vc);
        settle();
        lat  = (vc < 0 || hs < 0) ? -1 : vc - hs;
        npen = pen_total - pen0;
        for (int i = 0; i < NM; i++) pmask[i] = (psel_cnt[i] != snap[i]);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({axil.aw_ready, axil.w_ready, axil.ar_ready, axil.b_valid, axil.r_valid, apb.penable, pause_ack} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0", {axil.aw_ready, axil.w_ready, axil.ar_ready, axil.b_valid, axil.r_valid, apb.penable, pause_ack});
        end
        checks++;
        if ({apb.psel, apb.paddr, apb.pwdata, apb.pstrb, axil.b_resp, axil.r_resp, axil.r_data} !== '0) begin
            errors++;
            $display("FAIL reset_data: psel=%h paddr=%h pwdata=%h r_data=%h expected all 0", apb.psel, apb.paddr, apb.pwdata, axil.r_data);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_windows();
        logic [1:0] resp; logic [DW-1:0] rd; int lat, npen; logic [NM-1:0] pm; exp_t e;
        logic [AW-1:0] addrs[2];
        logic [DW-1:0] wd;
        for (int i = 0; i < NM; i++) begin
            addrs[0] = AW'(1024 * i);
            addrs[1] = AW'(1024 * (i + 1) - 1);
            for (int a = 0; a < 2; a++) begin
                for (int w = 1; w >= 0; w--) begin
                    wd = 32'hA500_0000 | DW'(i * 16 + a);
                    sb.push_back('{2'b00, (w == 1) ? 32'h0 : DW'(i), 3, NM'(1 << i)});
                    xfer(w == 1, addrs[a], wd, resp, rd, lat, pm, npen);
                    e = sb.pop_front();
                    checks++;
                    if (resp !== e.resp) begin errors++; $display("FAIL win_resp t%0d a%0d w%0d: got %b expected %b", i, a, w, resp, e.resp); end
                    checks++;
                    if (lat !== e.lat) begin errors++; $display("FAIL win_latency t%0d a%0d w%0d: got %0d expected %0d", i, a, w, lat, e.lat); end
                    checks++;
                    if (pm !== e.pmask) begin errors++; $display("FAIL win_psel t%0d a%0d w%0d: got %b expected %b", i, a, w, pm, e.pmask); end
                    checks++;
                    if (mon_paddr !== addrs[a]) begin errors++; $display("FAIL win_paddr t%0d a%0d: got %h expected %h", i, a, mon_paddr, addrs[a]); end
                    checks++;
                    if ({mon_pwrite, mon_pstrb, mon_pwdata} !== ((w == 1) ? {1'b1, 4'hF, wd} : 37'h0)) begin
                        errors++; $display("FAIL win_pwfields t%0d a%0d w%0d: got %b/%h/%h", i, a, w, mon_pwrite, mon_pstrb, mon_pwdata);
                    end
                    if (w == 0) begin
                        checks++;
                        if (rd !== e.data) begin errors++; $display("FAIL win_rdata t%0d a%0d: got %h expected %h", i, a, rd, e.data); end
                    end
                end
            end
        end
        checks++;
        if (psel_multi !== 0) begin errors++; $display("FAIL psel_onehot: got %0d multi-hot cycles expected 0", psel_multi); end
    endtask

    task automatic test_decerr();
        logic [1:0] resp; logic [DW-1:0] rd; int lat, npen; logic [NM-1:0] pm; exp_t e;
        for (int w = 1; w >= 0; w--) begin
            sb.push_back('{2'b11, 32'h0, 1, '0});
            xfer(w == 1, 32'h2000, 32'h1234_5678, resp, rd, lat, pm, npen);
            e = sb.pop_front();
            checks++;
            if (resp !== e.resp) begin errors++; $display("FAIL decerr_resp w%0d: got %b expected %b", w, resp, e.resp); end
            checks++;
            if (lat !== e.lat) begin errors++; $display("FAIL decerr_latency w%0d: got %0d expected %0d", w, lat, e.lat); end
            checks++;
            if ({pm, npen[7:0]} !== {e.pmask, 8'd0}) begin errors++; $display("FAIL decerr_noapb w%0d: psel=%b penable_cycles=%0d expected 0", w, pm, npen); end
            if (w == 0) begin
                checks++;
                if (rd !== e.data) begin errors++; $display("FAIL decerr_rdata: got %h expected %h", rd, e.data); end
            end
        end
    endtask

    task automatic test_slverr();
        logic [1:0] resp; logic [DW-1:0] rd; int lat, npen; logic [NM-1:0] pm; exp_t e;
        for (int pass = 0; pass < 2; pass++) begin
            tgt_err[3] = (pass == 0);
            for (int w = 1; w >= 0; w--) begin
                sb.push_back('{(pass == 0) ? 2'b10 : 2'b00, (w == 1) ? 32'h0 : 32'd3, 3, NM'(1 << 3)});
                xfer(w == 1, 32'hC04, 32'hCAFE_0003, resp, rd, lat, pm, npen);
                e = sb.pop_front();
                checks++;
                if (resp !== e.resp) begin errors++; $display("FAIL slverr_resp p%0d w%0d: got %b expected %b", pass, w, resp, e.resp); end
                if (pass == 1 && w == 0) begin
                    checks++;
                    if (rd !== e.data) begin errors++; $display("FAIL slverr_rdata: got %h expected %h", rd, e.data); end
                end
            end
        end
        tgt_err = '0;
    endtask

    task automatic test_timeout();
        logic [1:0] resp; logic [DW-1:0] rd; int lat, npen; logic [NM-1:0] pm; exp_t e;
        tgt_ready[5] = 1'b0;
        for (int w = 1; w >= 0; w--) begin
            sb.push_back('{2'b10, 32'h0, 18, NM'(1 << 5)});
            xfer(w == 1, 32'h1404, 32'h5555_0005, resp, rd, lat, pm, npen);
            e = sb.pop_front();
            checks++;
            if (npen !== 16) begin errors++; $display("FAIL timeout_penable w%0d: got %0d cycles expected 16", w, npen); end
            checks++;
            if (resp !== e.resp) begin errors++; $display("FAIL timeout_resp w%0d: got %b expected %b", w, resp, e.resp); end
            checks++;
            if (lat !== e.lat) begin errors++; $display("FAIL timeout_latency w%0d: got %0d expected %0d", w, lat, e.lat); end
            checks++;
            if (apb.psel !== '0) begin errors++; $display("FAIL timeout_psel_drop w%0d: got %b expected 0", w, apb.psel); end
            if (w == 0) begin
                checks++;
                if (rd !== e.data) begin errors++; $display("FAIL timeout_rdata: got %h expected %h", rd, e.data); end
            end
        end
        tgt_ready[5] = 1'b1;
        sb.push_back('{2'b00, 32'd5, 3, NM'(1 << 5)});
        xfer(1'b0, 32'h1400, 32'h0, resp, rd, lat, pm, npen);
        e = sb.pop_front();
        checks++;
        if ({resp, rd, lat[7:0]} !== {e.resp, e.data, 8'(e.lat)}) begin
            errors++; $display("FAIL timeout_recover: got resp=%b data=%h lat=%0d expected %b/%h/%0d", resp, rd, lat, e.resp, e.data, e.lat);
        end
    endtask

    task automatic run_pair(output byte o1, output byte o2);
        int  n;
        bit  wdone, rdone;
        n = 0; wdone = 0; rdone = 0; o1 = "-"; o2 = "-";
        @(negedge clk);
        axil.aw_addr = 32'h400; axil.w_data = 32'h0BAD_F00D; axil.w_strb = 4'hF;
        axil.ar_addr = 32'h800;
        axil.aw_valid = 1'b1; axil.w_valid = 1'b1; axil.ar_valid = 1'b1;
        for (int k = 0; k < 80 && !(wdone && rdone); k++) begin
            #1;
            if (!wdone && axil.aw_ready && axil.w_ready) begin
                wdone = 1; if (n == 0) o1 = "W"; else o2 = "W"; n++;
                @(posedge clk); #1 axil.aw_valid = 1'b0; axil.w_valid = 1'b0;
            end else if (!rdone && axil.ar_ready) begin
                rdone = 1; if (n == 0) o1 = "R"; else o2 = "R"; n++;
                @(posedge clk); #1 axil.ar_valid = 1'b0;
            end
            @(negedge clk);
        end
        axil.aw_valid = 1'b0; axil.w_valid = 1'b0; axil.ar_valid = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        byte o1, o2;
        logic [1:0] resp; logic [DW-1:0] rd; int vc, hs;
        run_pair(o1, o2);
        checks++;
        if ({o1, o2} !== {"W", "R"}) begin errors++; $display("FAIL arb_pair1: got %c%c expected WR", o1, o2); end
        run_pair(o1, o2);
        checks++;
        if ({o1, o2} !== {"R", "W"}) begin errors++; $display("FAIL arb_pair2: got %c%c expected RW", o1, o2); end

        tgt_err[3] = 1'b1;
        axil.b_ready = 1'b0;
        issue(1'b1, 32'hC00, 32'h3, hs);
        wait_resp(1'b1, resp, rd, vc);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({axil.b_valid, axil.b_resp} !== 3'b110) begin
                errors++; $display("FAIL bresp_hold c%0d: got valid=%b resp=%b expected 1/10", k, axil.b_valid, axil.b_resp);
            end
            @(negedge clk);
        end
        axil.b_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (axil.b_valid !== 1'b0) begin errors++; $display("FAIL bresp_release: got %b expected 0", axil.b_valid); end
        tgt_err[3] = 1'b0;
    endtask

    task automatic test_pause();
        logic [1:0] resp; logic [DW-1:0] rd; int vc, hs, hs_r, seen;
        tgt_ready[4] = 1'b0;
        issue(1'b1, 32'h1000, 32'h4444_0004, hs);
        repeat (3) @(negedge clk);
        pause_req = 1'b1;
        axil.ar_addr = 32'h404; axil.ar_prot = 3'b000; axil.ar_valid = 1'b1;
        @(negedge clk);
        tgt_ready[4] = 1'b1;
        wait_resp(1'b1, resp, rd, vc);
        checks++;
        if (resp !== 2'b00) begin errors++; $display("FAIL pause_inflight_resp: got %b expected 00", resp); end
        @(negedge clk);
        checks++;
        if ({pause_ack, axil.ar_ready} !== 2'b00) begin errors++; $display("FAIL pause_idle_first: got ack/ready=%b expected 00", {pause_ack, axil.ar_ready}); end
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) begin
                checks++;
                if (pause_ack !== 1'b1) begin errors++; $display("FAIL pause_ack_rise: got %b expected 1", pause_ack); end
            end
            #1 if (axil.ar_ready) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL pause_blocks_read: got %0d ready cycles expected 0", seen); end
        @(negedge clk);
        pause_req = 1'b0;
        #1;
        hs_r = axil.ar_ready ? cyc : -1;
        checks++;
        if (axil.ar_ready !== 1'b1) begin errors++; $display("FAIL pause_resume_ready: got %b expected 1", axil.ar_ready); end
        @(posedge clk); #1 axil.ar_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (pause_ack !== 1'b0) begin errors++; $display("FAIL pause_ack_fall: got %b expected 0", pause_ack); end
        sb.push_back('{2'b00, 32'd1, 3, '0});
        wait_resp(1'b0, resp, rd, vc);
        begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if ({resp, rd} !== {e.resp, e.data} || vc - hs_r !== e.lat) begin
                errors++; $display("FAIL pause_resumed_read: got resp=%b data=%h lat=%0d expected %b/%h/%0d", resp, rd, vc - hs_r, e.resp, e.data, e.lat);
            end
        end
    endtask

    task automatic test_reset_mid();
        int hs, bv0;
        logic [1:0] resp; logic [DW-1:0] rd; int lat, npen; logic [NM-1:0] pm;
        tgt_ready[5] = 1'b0;
        settle();
        issue(1'b1, 32'h1400, 32'h7777_0007, hs);
        repeat (4) @(negedge clk);
        checks++;
        if (apb.penable !== 1'b1) begin errors++; $display("FAIL rstmid_in_access: got penable=%b expected 1", apb.penable); end
        axil.ar_addr = 32'h400; axil.ar_valid = 1'b1;
        bv0 = bval_total;
        rst = 1'b0;
        #1;
        checks++;
        if ({apb.psel, apb.penable, axil.b_valid, axil.r_valid, axil.ar_ready, axil.aw_ready, pause_ack} !== '0) begin
            errors++; $display("FAIL rstmid_ctrl: psel=%b penable=%b b_valid=%b ar_ready=%b expected 0", apb.psel, apb.penable, axil.b_valid, axil.ar_ready);
        end
        checks++;
        if ({apb.paddr, apb.pwdata, apb.pstrb, axil.b_resp, axil.r_data} !== '0) begin
            errors++; $display("FAIL rstmid_data: paddr=%h pwdata=%h pstrb=%h expected 0", apb.paddr, apb.pwdata, apb.pstrb);
        end
        repeat (2) @(negedge clk);
        axil.ar_valid = 1'b0; tgt_ready[5] = 1'b1;
        rst = 1'b1;
        repeat (25) @(negedge clk);
        settle();
        checks++;
        if (bval_total !== bv0) begin errors++; $display("FAIL rstmid_no_resp: got %0d b_valid cycles expected 0", bval_total - bv0); end
        xfer(1'b0, 32'h408, 32'h0, resp, rd, lat, pm, npen);
        checks++;
        if ({resp, rd} !== {2'b00, 32'd1}) begin errors++; $display("FAIL rstmid_after: got resp=%b data=%h expected 00/1", resp, rd); end
    endtask

    initial begin
        for (int i = 0; i < NM; i++) begin
            tgt_rdata[i*DW +: DW] = DW'(i);
            psel_cnt[i] = 0;
        end
        axil.aw_addr = '0; axil.aw_prot = '0; axil.aw_valid = 1'b0;
        axil.w_data = '0; axil.w_strb = '0; axil.w_valid = 1'b0; axil.b_ready = 1'b1;
        axil.ar_addr = '0; axil.ar_prot = '0; axil.ar_valid = 1'b0; axil.r_ready = 1'b1;
        test_reset();
        test_windows();
        test_decerr();
        test_slverr();
        test_timeout();
        test_back_to_back();
        test_pause();
        test_reset_mid();
        checks++;
        if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
